// File: rtl/prio_grant_sched.sv
// prio_grant_sched: single-owner grant scheduler for 8 requesters.
// Arbitration is either fixed priority (bit 0 wins) or round-robin from a
// rotating pointer. A grant is held until the owner signals done or drops
// its request. It is forcibly revoked after MAX_HOLD cycles, with a
// one-cycle timeout_err pulse. Every release is followed by at least one
// idle cycle before the next grant.
module prio_grant_sched #(
  parameter int MAX_HOLD = 12,
  parameter int RR_RESET = 0
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [7:0] req,
  input  logic       mode,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_id,
  output logic       timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [2:0] PTR_INIT  = 3'(RR_RESET);

  state_t     state_reg, state_next;
  logic [7:0] gnt_reg, gnt_next;
  logic       valid_reg, valid_next;
  logic [2:0] id_reg, id_next;
  logic       timeout_reg, timeout_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [2:0] ptr_reg, ptr_next;

  logic [2:0] rot_idx [8];
  logic [2:0] fix_idx, rr_idx, win_idx;
  logic [7:0] win_onehot;
  logic       release_cond;

  // Candidate indices in round-robin scan order: ptr, ptr+1, ... (mod 8)
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_idx[gi] = ptr_reg + 3'(gi);
    end
  endgenerate

  // Winner selection: scan from the lowest-priority slot down, so the last hit is the winner
  always_comb begin
    fix_idx = 3'd0;
    rr_idx  = ptr_reg;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) fix_idx = 3'(i);
      if (req[rot_idx[i]]) rr_idx = rot_idx[i];
    end
    win_idx    = mode ? rr_idx : fix_idx;
    win_onehot = 8'b1 << win_idx;
  end

  // The owner gives up the grant by asserting done or by dropping its request
  assign release_cond = done | ~req[id_reg];

  // Next-state and next-output logic; outputs are registered
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    valid_next   = valid_reg;
    id_next      = id_reg;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    case (state_reg)
      IDLE: begin
        gnt_next   = 8'h00;
        valid_next = 1'b0;
        if (|req) begin
          gnt_next   = win_onehot;
          id_next    = win_idx;
          valid_next = 1'b1;
          cnt_next   = 4'd0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg + 4'd1;
        // A normal release takes precedence over a coincident timeout
        if (release_cond || cnt_reg == HOLD_LAST) begin
          gnt_next     = 8'h00;
          valid_next   = 1'b0;
          state_next   = IDLE;
          ptr_next     = id_reg + 3'd1;
          timeout_next = ~release_cond;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg   <= IDLE;
      gnt_reg     <= 8'h00;
      valid_reg   <= 1'b0;
      id_reg      <= 3'd0;
      timeout_reg <= 1'b0;
      cnt_reg     <= 4'd0;
      ptr_reg     <= PTR_INIT;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= valid_next;
      id_reg      <= id_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign gnt         = gnt_reg;
  assign gnt_valid   = valid_reg;
  assign gnt_id      = id_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_prio_grant_sched.sv
// Bench for prio_grant_sched: table-driven per-cycle vectors followed by
// hand-written sequences for timeout, done/timeout collision, async reset
// and round-robin rotation.
module tb_prio_grant_sched;

  logic       clk;
  logic       areset;
  logic [7:0] req;
  logic       mode;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout_err;

  int n_cmp;
  int n_fail;

  prio_grant_sched #(.MAX_HOLD(12), .RR_RESET(0)) dut (
    .clk         (clk),
    .areset      (areset),
    .req         (req),
    .mode        (mode),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       done;
    logic [7:0] e_gnt;
    logic       e_valid;
    logic [2:0] e_id;
    logic       e_to;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 areset = 1'b1;
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_valid", {7'd0, gnt_valid}, 8'd0);
    chk("rst_id", {5'd0, gnt_id}, 8'd0);
    chk("rst_to", {7'd0, timeout_err}, 8'd0);
    #1 areset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    req    = 8'h00;
    mode   = 1'b0;
    done   = 1'b0;
    areset = 1'b1;

    //          req    mode  done   gnt    valid id    to
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{8'hA4, 1'b0, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    tbl[2]  = '{8'hA4, 1'b0, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    tbl[3]  = '{8'hA4, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0}; // ptr -> 3
    tbl[4]  = '{8'h05, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0}; // wrap from 3
    tbl[5]  = '{8'h05, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}; // ptr -> 1
    tbl[6]  = '{8'h05, 1'b1, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    tbl[7]  = '{8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0}; // owner drops req
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
    tbl[9]  = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[10] = '{8'h81, 1'b0, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0}; // non-owner ignored
    tbl[11] = '{8'h81, 1'b0, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0}; // ptr -> 0
    tbl[12] = '{8'hFF, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[13] = '{8'hFF, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0}; // mode flip while busy
    tbl[14] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}; // ptr -> 1
    tbl[15] = '{8'h81, 1'b1, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0}; // rr from 1 picks 7
    tbl[16] = '{8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0};

    // Reset state, checked while reset is held
    #3;
    chk("reset_gnt", gnt, 8'h00);
    chk("reset_valid", {7'd0, gnt_valid}, 8'd0);
    chk("reset_id", {5'd0, gnt_id}, 8'd0);
    chk("reset_to", {7'd0, timeout_err}, 8'd0);
    #4 areset = 1'b0;

    // Table vectors: inputs before the edge, outputs checked after it
    for (int v = 0; v < 17; v++) begin
      req  = tbl[v].req;
      mode = tbl[v].mode;
      done = tbl[v].done;
      step();
      chk($sformatf("v%0d_gnt", v), gnt, tbl[v].e_gnt);
      chk($sformatf("v%0d_valid", v), {7'd0, gnt_valid}, {7'd0, tbl[v].e_valid});
      chk($sformatf("v%0d_id", v), {5'd0, gnt_id}, {5'd0, tbl[v].e_id});
      chk($sformatf("v%0d_to", v), {7'd0, timeout_err}, {7'd0, tbl[v].e_to});
      $display("vec %0d req=%h mode=%0d done=%0d -> gnt=%h valid=%0d id=%0d to=%0d",
               v, req, mode, done, gnt, gnt_valid, gnt_id, timeout_err);
    end

    // Forced release after 12 held cycles
    mode = 1'b0; req = 8'h08; done = 1'b0;
    step();
    chk("to_grant", gnt, 8'h08);
    for (int k = 1; k < 12; k++) begin
      step();
      chk($sformatf("to_hold%0d", k), {6'd0, gnt_valid, timeout_err}, 8'b10);
    end
    step();
    chk("to_release", {gnt[3], gnt_valid, timeout_err}, 8'b001);
    req = 8'h00;
    step();
    chk("to_pulse_end", {6'd0, gnt_valid, timeout_err}, 8'b00);
    $display("seq timeout: forced release observed");

    // done arrives on the same cycle the hold limit is reached
    req = 8'h10;
    step();
    chk("dc_grant", {5'd0, gnt_id}, 8'd4);
    for (int k = 1; k < 12; k++) step();
    chk("dc_still_held", {6'd0, gnt_valid, timeout_err}, 8'b10);
    done = 1'b1;
    step();
    chk("dc_release", {6'd0, gnt_valid, timeout_err}, 8'b00);
    done = 1'b0; req = 8'h00;
    step();
    chk("dc_no_pulse", {7'd0, timeout_err}, 8'd0);
    $display("seq done+timeout: normal release");

    // Asynchronous reset during a grant to requester 5
    req = 8'h20;
    step();
    chk("ar_grant", {5'd0, gnt_id}, 8'd5);
    step();
    pulse_reset();
    mode = 1'b1; req = 8'h21;
    step();
    chk("ar_ptr_reset", gnt, 8'h01);
    done = 1'b1;
    step();
    chk("ar_release", gnt, 8'h00);
    done = 1'b0; req = 8'h00;
    $display("seq async reset: grant dropped, ptr restored");

    // Round-robin rotation with all requesters active
    step();
    pulse_reset();
    mode = 1'b1; req = 8'hFF; done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_oh;
      exp_oh = 8'h01 << (k % 8);
      step();
      chk($sformatf("rr%0d_grant", k), gnt, exp_oh);
      step();
      chk($sformatf("rr%0d_hold", k), gnt, exp_oh);
      done = 1'b1;
      step();
      chk($sformatf("rr%0d_gap", k), gnt, 8'h00);
      done = 1'b0;
      $display("seq rr: grant %0d rotated", k % 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
